// File: rtl/case_3_acc_11s_12s_8.sv
// Frame accumulator: sums LEN signed products and presents the sum with a sticky overflow flag.
// Define CASE_3_ACC_SATURATE_EN to clamp each step instead of wrapping.
module case_3_acc_11s_12s_8 #(
  parameter int ID         = 1,
  parameter int din_WIDTH  = 11,
  parameter int dout_WIDTH = 12,
  parameter int LEN        = 8
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic signed [din_WIDTH-1:0]  din,
  input  logic                         din_vld,
  output logic                         din_rdy,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic                         dout_vld,
  input  logic                         dout_rdy,
  output logic                         ovf
);

  localparam int CW = $clog2(LEN + 1);

  // Handshake: a beat moves on a cycle where din_vld && din_rdy; the result
  // moves on a cycle where dout_vld && dout_rdy. Neither side may retract.
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                       state;
  state_t                       state_nxt;
  logic signed [dout_WIDTH-1:0] acc;
  logic [CW-1:0]                cnt;
  logic                         ovf_sticky;
  logic signed [dout_WIDTH:0]   sum;
  logic                         step_ovf;
  logic signed [dout_WIDTH-1:0] step_val;
  logic                         accept;
  logic                         last;
  logic                         release_out;

  assign din_rdy     = (state != HOLD);
  assign accept      = din_vld && din_rdy;
  assign last        = accept && (cnt == CW'(LEN - 1));
  assign release_out = (state == HOLD) && dout_rdy;

  // One guard bit above the result width catches any single-step overflow.
  always_comb begin
    sum      = {{(dout_WIDTH + 1 - din_WIDTH){din[din_WIDTH-1]}}, din}
             + {acc[dout_WIDTH-1], acc};
    step_ovf = sum[dout_WIDTH] ^ sum[dout_WIDTH-1];
`ifdef CASE_3_ACC_SATURATE_EN
    if (step_ovf)
      step_val = sum[dout_WIDTH] ? {1'b1, {(dout_WIDTH-1){1'b0}}}
                                 : {1'b0, {(dout_WIDTH-1){1'b1}}};
    else
      step_val = sum[dout_WIDTH-1:0];
`else
    step_val = sum[dout_WIDTH-1:0];
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACC;
      ACC:     if (last) state_nxt = HOLD;
      HOLD:    if (dout_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      ovf_sticky <= 1'b0;
      dout       <= '0;
      dout_vld   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc        <= step_val;
        cnt        <= cnt + 1'b1;
        ovf_sticky <= ovf_sticky | step_ovf;
        if (last) begin
          dout     <= step_val;
          ovf      <= ovf_sticky | step_ovf;
          dout_vld <= 1'b1;
        end
      end
      // din_rdy is low in HOLD, so this never collides with an accepted beat.
      if (release_out) begin
        acc        <= '0;
        cnt        <= '0;
        ovf_sticky <= 1'b0;
        ovf        <= 1'b0;
        dout_vld   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_case_3_acc_11s_12s_8.sv
// Bench for case_3_acc_11s_12s_8: directed frames, scoreboard queue of {ovf,dout}.
module tb_case_3_acc_11s_12s_8;

  logic               clk;
  logic               rst;
  logic signed [10:0] din;
  logic               din_vld;
  logic               din_rdy;
  logic signed [11:0] dout;
  logic               dout_vld;
  logic               dout_rdy;
  logic               ovf;

  logic [12:0] exp_q[$];
  int total;
  int bad;

  case_3_acc_11s_12s_8 #(.ID(1), .din_WIDTH(11), .dout_WIDTH(12), .LEN(8)) dut (
    .ap_clk(clk), .ap_rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .ovf(ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && dout_vld && dout_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h want none", {ovf, dout});
      end else begin
        check("frame_out", {ovf, dout}, exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic send_beats(input logic signed [10:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gap; g++) begin
        din     = 11'($urandom_range(0, 2047));
        din_vld = 1'b0;
        @(posedge clk); #1;
      end
      din     = v;
      din_vld = 1'b1;
      @(posedge clk); #1;
      din_vld = 1'b0;
      din     = 11'($urandom_range(0, 2047));
    end
  endtask

  task automatic frame(input logic signed [10:0] v, input int gap,
                       input logic signed [11:0] exp_dout, input logic exp_ovf);
    exp_q.push_back({exp_ovf, exp_dout});
    send_beats(v, 7, gap);
    check("pre_last_vld", 13'(dout_vld), 13'd0);
    send_beats(v, 1, gap);
    check("latency_vld", 13'(dout_vld), 13'd1);
    if (dout_rdy) begin
      @(posedge clk); #1;
      check("vld_one_cycle", 13'(dout_vld), 13'd0);
      check("idle_rdy", 13'(din_rdy), 13'd1);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    check("rst_async_vld", 13'(dout_vld), 13'd0);
    check("rst_async_rdy", 13'(din_rdy), 13'd1);
    check("rst_async_out", {ovf, dout}, 13'd0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    din      = '0;
    din_vld  = 1'b0;
    dout_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_vld", 13'(dout_vld), 13'd0);
    check("reset_rdy", 13'(din_rdy), 13'd1);
    check("reset_out", {ovf, dout}, 13'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    frame(11'sd100, 0, 12'sd800, 1'b0);
`ifdef CASE_3_ACC_SATURATE_EN
    frame(11'sd1023, 0, 12'sd2047, 1'b1);
    frame(11'h400, 0, 12'h800, 1'b1);
`else
    frame(11'sd1023, 0, -12'sd8, 1'b1);
    frame(11'h400, 0, 12'sd0, 1'b1);
`endif
    frame(11'sd100, 0, 12'sd800, 1'b0);

    // stall in HOLD with din_vld asserted; those beats must be ignored
    dout_rdy = 1'b0;
    frame(-11'sd5, 0, -12'sd40, 1'b0);
    din     = 11'sd500;
    din_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_vld", 13'(dout_vld), 13'd1);
      check("stall_out", {ovf, dout}, {1'b0, -12'sd40});
      check("stall_rdy", 13'(din_rdy), 13'd0);
    end
    dout_rdy = 1'b1;
    @(posedge clk); #1;
    check("release_vld", 13'(dout_vld), 13'd0);
    check("release_rdy", 13'(din_rdy), 13'd1);
    din_vld = 1'b0;
    frame(11'sd10, 0, 12'sd80, 1'b0);

    // reset mid-frame
    send_beats(11'sd50, 3, 0);
    rst_pulse();
    frame(-11'sd3, 0, -12'sd24, 1'b0);

    // reset while holding an unconsumed result
    dout_rdy = 1'b0;
    send_beats(11'sd9, 8, 0);
    check("hold_before_rst", 13'(dout_vld), 13'd1);
    rst_pulse();
    dout_rdy = 1'b1;

    // sparse input: gaps must not disturb the sum or the latency
    frame(11'sd7, 1, 12'sd56, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", 13'(exp_q.size()), 13'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
